mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (MIPS data port, DMA), the arbiter and the
// single-port synchronous Memory.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30
);
    logic                  req0, req1;
    logic                  lock0, lock1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [3:0]            wbe0, wbe1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  ack0, ack1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_ce;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [3:0]            mem_wbe;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    // Arbiter side.
    modport slave (
        input  req0, req1, lock0, lock1, addr0, addr1, wbe0, wbe1, wdata0, wdata1,
        input  mem_data_out,
        output gnt0, gnt1, ack0, ack1, rdata,
        output mem_ce, mem_address, mem_wbe, mem_data_in
    );

    // Requesters plus memory side.
    modport master (
        output req0, req1, lock0, lock1, addr0, addr1, wbe0, wbe1, wdata0, wdata1,
        output mem_data_out,
        input  gnt0, gnt1, ack0, ack1, rdata,
        input  mem_ce, mem_address, mem_wbe, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous Memory: tie-break against
// the last owner, MAX_HOLD fairness preemption unless locked, zero-bubble hand-over.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int MAX_HOLD   = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       last_q, last_d;
    logic       ack0_q, ack1_q;
    logic       issue0, issue1;

    assign issue0 = (state_q == ST_OWN0) && bus.req0;
    assign issue1 = (state_q == ST_OWN1) && bus.req1;

    // The owner's request drives Memory in the same cycle; everything idles at zero otherwise.
    always_comb begin
        bus.mem_ce      = 1'b0;
        bus.mem_address = '0;
        bus.mem_wbe     = 4'b0000;
        bus.mem_data_in = '0;
        if (issue0) begin
            bus.mem_ce      = 1'b1;
            bus.mem_address = bus.addr0;
            bus.mem_wbe     = bus.wbe0;
            bus.mem_data_in = bus.wdata0;
        end else if (issue1) begin
            bus.mem_ce      = 1'b1;
            bus.mem_address = bus.addr1;
            bus.mem_wbe     = bus.wbe1;
            bus.mem_data_in = bus.wdata1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OWN0: begin
                if (!bus.req0)
                    state_d = bus.req1 ? ST_OWN1 : ST_IDLE;
                else if (!bus.lock0 && bus.req1 && hold_q == HOLD_LAST)
                    state_d = ST_OWN1;
            end
            ST_OWN1: begin
                if (!bus.req1)
                    state_d = bus.req0 ? ST_OWN0 : ST_IDLE;
                else if (!bus.lock1 && bus.req0 && hold_q == HOLD_LAST)
                    state_d = ST_OWN0;
            end
            default: begin
                if (bus.req0 && bus.req1)
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                else if (bus.req0)
                    state_d = ST_OWN0;
                else if (bus.req1)
                    state_d = ST_OWN1;
                else
                    state_d = ST_IDLE;
            end
        endcase
    end

    // Hold counter restarts with every ownership change and sticks at the preemption point.
    always_comb begin
        hold_d = hold_q;
        if (state_d != state_q)
            hold_d = 8'd0;
        else if ((issue0 || issue1) && hold_q != HOLD_LAST)
            hold_d = hold_q + 8'd1;

        last_d = last_q;
        if (state_d == ST_OWN0 && state_q != ST_OWN0)
            last_d = 1'b0;
        else if (state_d == ST_OWN1 && state_q != ST_OWN1)
            last_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= 8'd0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            ack0_q  <= issue0;
            ack1_q  <= issue1;
        end
    end

    assign bus.gnt0  = (state_q == ST_OWN0);
    assign bus.gnt1  = (state_q == ST_OWN1);
    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.rdata = bus.mem_data_out;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a scoreboard queues each issued access with the data the
// reference memory predicts and retires it against the following ack.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(30)) bus ();
    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(30), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        port;
        logic        is_read;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sim_mem [0:63];
    logic [31:0] ref_mem [0:63];
    int          passed = 0;
    int          total  = 0;

    // Synchronous Memory model with byte enables and one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_ce) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_wbe[b])
                    sim_mem[bus.mem_address[5:0]][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
            bus.mem_data_out <= sim_mem[bus.mem_address[5:0]];
        end
    end

    task automatic monitor();
        exp_t         e;
        logic         iss0, iss1;
        logic [66:0]  exp_bus, got_bus;
        logic [5:0]   a;
        logic [3:0]   w;
        logic [31:0]  wd;
        total++; if ((bus.gnt0 & bus.gnt1) !== 1'b0) $display("FAIL gnt_exclusive: gnt0=%b gnt1=%b required not both", bus.gnt0, bus.gnt1); else passed++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({bus.ack1, bus.ack0} !== (e.port ? 2'b10 : 2'b01))
                $display("FAIL ack_port: {ack1,ack0}=%b required %b", {bus.ack1, bus.ack0}, e.port ? 2'b10 : 2'b01);
            else passed++;
            $display("ack port=%0d addr=0x%02h %s rdata=0x%08h", e.port, e.addr, e.is_read ? "rd" : "wr", bus.rdata);
            if (e.is_read) begin
                total++; if (bus.rdata !== e.data) $display("FAIL rdata: got 0x%08h required 0x%08h", bus.rdata, e.data); else passed++;
            end
        end else begin
            total++; if ({bus.ack1, bus.ack0} !== 2'b00) $display("FAIL spurious_ack: {ack1,ack0}=%b required 00", {bus.ack1, bus.ack0}); else passed++;
        end
        iss0 = bus.gnt0 & bus.req0;
        iss1 = bus.gnt1 & bus.req1;
        exp_bus = '0;
        if (iss0)      exp_bus = {1'b1, bus.addr0, bus.wbe0, bus.wdata0};
        else if (iss1) exp_bus = {1'b1, bus.addr1, bus.wbe1, bus.wdata1};
        got_bus = {bus.mem_ce, bus.mem_address, bus.mem_wbe, bus.mem_data_in};
        total++; if (got_bus !== exp_bus) $display("FAIL mem_bus: got %h required %h", got_bus, exp_bus); else passed++;
        if (iss0 || iss1) begin
            a  = iss0 ? bus.addr0[5:0] : bus.addr1[5:0];
            w  = iss0 ? bus.wbe0 : bus.wbe1;
            wd = iss0 ? bus.wdata0 : bus.wdata1;
            e.port = iss1; e.is_read = (w == 4'b0000); e.addr = a; e.data = ref_mem[a];
            exp_q.push_back(e);
            for (int b = 0; b < 4; b++)
                if (w[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end
        if (rst) exp_q.delete();
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1;
        advance();
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({bus.gnt1, bus.gnt0, bus.ack1, bus.ack0, bus.mem_ce} !== 5'b0) $display("FAIL reset_outputs: {gnt1,gnt0,ack1,ack0,ce}=%b required 00000", {bus.gnt1, bus.gnt0, bus.ack1, bus.ack0, bus.mem_ce}); else passed++;
            advance();
        end
        rst = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();
        total++; if ({bus.gnt1, bus.gnt0} !== 2'b00) $display("FAIL reset_idle: {gnt1,gnt0}=%b required 00", {bus.gnt1, bus.gnt0}); else passed++;
        advance();
    endtask

    task automatic test_single_read();
        bus.req0 = 1'b1; bus.addr0 = 30'h10; bus.wbe0 = 4'b0000;
        step();
        total++; if ({bus.gnt0, bus.mem_ce} !== 2'b00) $display("FAIL read_c0: {gnt0,ce}=%b required 00", {bus.gnt0, bus.mem_ce}); else passed++;
        advance(); step();
        total++; if ({bus.gnt0, bus.mem_ce, bus.mem_address} !== {2'b11, 30'h10}) $display("FAIL read_c1: gnt0=%b ce=%b addr=%h required 1 1 10", bus.gnt0, bus.mem_ce, bus.mem_address); else passed++;
        advance(); bus.req0 = 1'b0; step();
        total++; if ({bus.ack0, bus.rdata} !== {1'b1, 32'h11223344}) $display("FAIL read_c2: ack0=%b rdata=%h required 1 11223344", bus.ack0, bus.rdata); else passed++;
        advance(); step();
        total++; if (bus.gnt0 !== 1'b0) $display("FAIL read_c3: gnt0=%b required 0", bus.gnt0); else passed++;
        advance();
    endtask

    task automatic test_tie();
        rst = 1'b1; step(); advance(); rst = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 30'h11; bus.addr1 = 30'h12;
        step(); advance(); step();
        total++; if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL tie_first: {gnt1,gnt0}=%b required 01", {bus.gnt1, bus.gnt0}); else passed++;
        advance(); bus.req0 = 1'b0; step();
        total++; if ({bus.gnt1, bus.gnt0, bus.ack0} !== 3'b011) $display("FAIL tie_release: {gnt1,gnt0,ack0}=%b required 011", {bus.gnt1, bus.gnt0, bus.ack0}); else passed++;
        advance(); step();
        total++; if ({bus.gnt1, bus.gnt0} !== 2'b10) $display("FAIL tie_second: {gnt1,gnt0}=%b required 10", {bus.gnt1, bus.gnt0}); else passed++;
        advance(); bus.req1 = 1'b0; step(); advance(); step(); advance();
    endtask

    task automatic test_max_hold();
        logic [1:0] exp_gnt, prev_gnt;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.wbe0 = 4'b0000; bus.wbe1 = 4'b0000;
        bus.addr0 = 30'h20; bus.addr1 = 30'h08;
        step(); advance();
        prev_gnt = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            bus.addr0 = 30'h20 + 30'(k); bus.addr1 = 30'h08 + 30'(k);
            step();
            exp_gnt = (((k - 1) / 4) % 2 == 1) ? 2'b10 : 2'b01;
            total++; if ({bus.gnt1, bus.gnt0} !== exp_gnt) $display("FAIL hold_gnt c%0d: {gnt1,gnt0}=%b required %b", k, {bus.gnt1, bus.gnt0}, exp_gnt); else passed++;
            if (k >= 2) begin
                total++; if ({bus.ack1, bus.ack0} !== prev_gnt) $display("FAIL hold_ack c%0d: {ack1,ack0}=%b required %b", k, {bus.ack1, bus.ack0}, prev_gnt); else passed++;
            end
            prev_gnt = exp_gnt;
            advance();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();
        total++; if (bus.ack1 !== 1'b1) $display("FAIL hold_last_ack: ack1=%b required 1", bus.ack1); else passed++;
        advance(); step(); advance();
    endtask

    task automatic test_lock();
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 30'h2A; bus.wbe0 = 4'b0000; bus.req1 = 1'b0;
        step(); advance();
        for (int k = 1; k <= 10; k++) begin
            bus.req1 = 1'b1; bus.addr1 = 30'h2B;
            if (k == 10) bus.req0 = 1'b0;
            step();
            total++; if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL lock_hold c%0d: {gnt1,gnt0}=%b required 01", k, {bus.gnt1, bus.gnt0}); else passed++;
            advance();
        end
        step();
        total++; if ({bus.gnt1, bus.gnt0} !== 2'b10) $display("FAIL lock_handover: {gnt1,gnt0}=%b required 10", {bus.gnt1, bus.gnt0}); else passed++;
        advance(); bus.req1 = 1'b0; bus.lock0 = 1'b0;
        step(); advance(); step(); advance();
    endtask

    task automatic test_byte_write();
        bus.req1 = 1'b1; bus.addr1 = 30'd5; bus.wbe1 = 4'b0011; bus.wdata1 = 32'hAABBCCDD;
        step(); advance(); step();
        total++; if ({bus.gnt1, bus.mem_wbe} !== 5'b1_0011) $display("FAIL bw_wbe: gnt1=%b mem_wbe=%b required 1 0011", bus.gnt1, bus.mem_wbe); else passed++;
        advance(); bus.wbe1 = 4'b0000; bus.wdata1 = 32'h0;
        step();
        total++; if (bus.ack1 !== 1'b1) $display("FAIL bw_write_ack: ack1=%b required 1", bus.ack1); else passed++;
        advance(); bus.req1 = 1'b0; step();
        total++; if ({bus.ack1, bus.rdata} !== {1'b1, 32'h5566CCDD}) $display("FAIL bw_readback: ack1=%b rdata=%h required 1 5566ccdd", bus.ack1, bus.rdata); else passed++;
        advance(); step(); advance();
    endtask

    task automatic test_reset_mid();
        bus.req1 = 1'b1; bus.addr1 = 30'd7; bus.wbe1 = 4'b0000;
        step(); advance();
        rst = 1'b1; step();
        total++; if ({bus.gnt1, bus.mem_ce} !== 2'b11) $display("FAIL rm_issue: {gnt1,ce}=%b required 11", {bus.gnt1, bus.mem_ce}); else passed++;
        advance(); rst = 1'b0; bus.req0 = 1'b1; bus.addr0 = 30'd9; bus.wbe0 = 4'b0000;
        step();
        total++; if ({bus.ack1, bus.gnt1, bus.gnt0, bus.mem_ce} !== 4'b0000) $display("FAIL rm_after: {ack1,gnt1,gnt0,ce}=%b required 0000", {bus.ack1, bus.gnt1, bus.gnt0, bus.mem_ce}); else passed++;
        advance(); step();
        total++; if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL rm_tie: {gnt1,gnt0}=%b required 01", {bus.gnt1, bus.gnt0}); else passed++;
        advance(); bus.req0 = 1'b0; bus.req1 = 1'b0;
        step(); advance(); step(); advance();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            sim_mem[i] = 32'hA5000000 ^ (32'(i) * 32'h00010203);
            ref_mem[i] = sim_mem[i];
        end
        sim_mem[16] = 32'h11223344; ref_mem[16] = 32'h11223344;
        sim_mem[5]  = 32'h55667788; ref_mem[5]  = 32'h55667788;
        bus.mem_data_out = 32'h0;
        bus.lock0 = 1'b0; bus.lock1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wbe0 = '0; bus.wbe1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        test_reset();
        test_single_read();
        test_tie();
        test_max_hold();
        test_lock();
        test_byte_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
